// File: rtl/flash_reader_pkg.sv
// flash_reader_pkg: constants shared by flash_reader and flash_reg_poll.
//   - register select codes of the SPI flash register interface
//   - flash read opcodes
//   - sequencer state encoding
package flash_reader_pkg;

  localparam logic [3:0] REG_SO_RDY = 4'd0;
  localparam logic [3:0] REG_SO_DAT = 4'd1;
  localparam logic [3:0] REG_SI_RDY = 4'd2;
  localparam logic [3:0] REG_SI_DAT = 4'd3;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_TX_POLL = 4'd1,
    ST_TX_CHK  = 4'd2,
    ST_TX_WR   = 4'd3,
    ST_RX_POLL = 4'd4,
    ST_RX_CHK  = 4'd5,
    ST_RX_RD   = 4'd6,
    ST_RX_CAP  = 4'd7,
    ST_OUT     = 4'd8,
    ST_FIN     = 4'd9
  } state_e;

endpackage

// File: rtl/flash_reg_poll.sv
// flash_reg_poll: ready-poll helper shared by the TX and RX wait phases.
// Issues the status read (SO_RDY or SI_RDY by sel_rx_i), evaluates the read
// data in the following check cycle and counts failed polls of the current
// wait, flagging a timeout on the POLL_LIMIT-th consecutive failure.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   clr_i          clear the failed-poll counter (sequencer idle)
//   issue_i        poll read cycle
//   check_i        cycle in which rdata_i holds the poll result
//   sel_rx_i       0: poll SO_RDY, 1: poll SI_RDY
//   rdata_i        register read data
//   en_o, addr_o   poll read strobe and register select
//   ready_o        poll succeeded (check cycle, nonzero data)
//   timeout_o      poll failed for the POLL_LIMIT-th time in a row
module flash_reg_poll
  import flash_reader_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int POLL_LIMIT = 1023
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             issue_i,
  input  logic             check_i,
  input  logic             sel_rx_i,
  input  logic [WIDTH-1:0] rdata_i,
  output logic             en_o,
  output logic [3:0]       addr_o,
  output logic             ready_o,
  output logic             timeout_o
);

  localparam int CW = $clog2(POLL_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fail;

  assign en_o      = issue_i;
  assign addr_o    = sel_rx_i ? REG_SI_RDY : REG_SO_RDY;
  assign ready_o   = check_i && (rdata_i != '0);
  assign fail      = check_i && (rdata_i == '0);
  assign timeout_o = fail && (cnt_q == CW'(POLL_LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || ready_o || timeout_o) begin
      cnt_d = '0;
    end else if (fail) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/flash_reader.sv
// flash_reader: turns "read i_len bytes at flash address i_faddr" into
// register-level traffic on the SPI flash register interface and streams
// the payload bytes out over a valid/ready handshake.
// Per byte: poll SO_RDY, write SO_DAT, poll SI_RDY, read SI_DAT, capture.
// Header bytes (opcode + address [+ dummy]) are echoed back and discarded.
// Optional build macro: FLASH_READER_FAST_EN selects fast read (0x0B plus
// one dummy byte); otherwise plain read (0x03).
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_start, i_faddr, i_len   request (sampled in IDLE only)
//   o_busy, o_done, o_err     status; o_err is a poll timeout flag
//   o_valid, o_byte, i_ready  payload stream
//   o_reg_*, i_reg_rdata      register bus master port
module flash_reader
  import flash_reader_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = 8,
  parameter int POLL_LIMIT = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [23:0]      i_faddr,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_byte,
  input  logic             i_ready,
  output logic             o_reg_en,
  output logic             o_reg_wr,
  output logic [3:0]       o_reg_addr,
  output logic [WIDTH-1:0] o_reg_wdata,
  input  logic [WIDTH-1:0] i_reg_rdata
);

`ifdef FLASH_READER_FAST_EN
  localparam int               HDR    = 5;
  localparam logic [WIDTH-1:0] OPCODE = WIDTH'(CMD_FAST_READ);
`else
  localparam int               HDR    = 4;
  localparam logic [WIDTH-1:0] OPCODE = WIDTH'(CMD_READ);
`endif

  // Index spans header plus a full-scale length without wrapping.
  localparam int IW = LEN_W + 3;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [23:0]      faddr_q, faddr_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] byte_q, byte_d;

  logic             poll_en, poll_ready, poll_timeout;
  logic [3:0]       poll_addr;
  logic             discard, is_last, advance;
  logic [WIDTH-1:0] cur_byte;

  flash_reg_poll #(
    .WIDTH      (WIDTH),
    .POLL_LIMIT (POLL_LIMIT)
  ) u_poll (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .clr_i     (state_q == ST_IDLE),
    .issue_i   ((state_q == ST_TX_POLL) || (state_q == ST_RX_POLL)),
    .check_i   ((state_q == ST_TX_CHK) || (state_q == ST_RX_CHK)),
    .sel_rx_i  ((state_q == ST_RX_POLL) || (state_q == ST_RX_CHK)),
    .rdata_i   (i_reg_rdata),
    .en_o      (poll_en),
    .addr_o    (poll_addr),
    .ready_o   (poll_ready),
    .timeout_o (poll_timeout)
  );

  assign discard = idx_q < IW'(HDR);
  assign is_last = idx_q == (IW'(len_q) + IW'(HDR - 1));

  // Transmit byte for the current index; payload phase clocks out zeros.
  always_comb begin
    cur_byte = '0;
    case (idx_q)
      IW'(0):  cur_byte = OPCODE;
      IW'(1):  cur_byte = WIDTH'(faddr_q[23:16]);
      IW'(2):  cur_byte = WIDTH'(faddr_q[15:8]);
      IW'(3):  cur_byte = WIDTH'(faddr_q[7:0]);
      default: cur_byte = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    faddr_d = faddr_q;
    err_d   = err_q;
    byte_d  = byte_q;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          err_d = 1'b0;
          if (i_len == '0) begin
            state_d = ST_FIN;
          end else begin
            len_d   = i_len;
            faddr_d = i_faddr;
            idx_d   = '0;
            state_d = ST_TX_POLL;
          end
        end
      end
      ST_TX_POLL: state_d = ST_TX_CHK;
      ST_TX_CHK: begin
        if (poll_timeout) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (poll_ready) begin
          state_d = ST_TX_WR;
        end else begin
          state_d = ST_TX_POLL;
        end
      end
      ST_TX_WR:   state_d = ST_RX_POLL;
      ST_RX_POLL: state_d = ST_RX_CHK;
      ST_RX_CHK: begin
        if (poll_timeout) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (poll_ready) begin
          state_d = ST_RX_RD;
        end else begin
          state_d = ST_RX_POLL;
        end
      end
      ST_RX_RD: state_d = ST_RX_CAP;
      ST_RX_CAP: begin
        if (discard) begin
          advance = 1'b1;
        end else begin
          byte_d  = i_reg_rdata;
          state_d = ST_OUT;
        end
      end
      ST_OUT:   advance = i_ready;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (advance) begin
      if (is_last) begin
        state_d = ST_FIN;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_TX_POLL;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      faddr_q <= '0;
      err_q   <= 1'b0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      faddr_q <= faddr_d;
      err_q   <= err_d;
      byte_q  <= byte_d;
    end
  end

  assign o_busy      = !((state_q == ST_IDLE) || (state_q == ST_FIN));
  assign o_done      = state_q == ST_FIN;
  assign o_err       = err_q;
  assign o_valid     = state_q == ST_OUT;
  assign o_byte      = byte_q;
  assign o_reg_wr    = state_q == ST_TX_WR;
  assign o_reg_en    = poll_en || (state_q == ST_TX_WR) || (state_q == ST_RX_RD);
  assign o_reg_wdata = (state_q == ST_TX_WR) ? cur_byte : '0;

  always_comb begin
    o_reg_addr = 4'd0;
    if (poll_en) begin
      o_reg_addr = poll_addr;
    end else if (state_q == ST_TX_WR) begin
      o_reg_addr = REG_SO_DAT;
    end else if (state_q == ST_RX_RD) begin
      o_reg_addr = REG_SI_DAT;
    end
  end

endmodule

// File: tb/tb_flash_reader.sv
module tb_flash_reader;

  localparam int LIM = 16;
`ifdef FLASH_READER_FAST_EN
  localparam int         HDR = 5;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int         HDR = 4;
  localparam logic [7:0] OPC = 8'h03;
`endif

  logic        i_clk, i_rst_n, i_start, i_ready;
  logic [23:0] i_faddr;
  logic [7:0]  i_len, i_reg_rdata;
  logic        o_busy, o_done, o_err, o_valid, o_reg_en, o_reg_wr;
  logic [7:0]  o_byte, o_reg_wdata;
  logic [3:0]  o_reg_addr;

  flash_reader #(.WIDTH(8), .LEN_W(8), .POLL_LIMIT(LIM)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_faddr(i_faddr),
    .i_len(i_len), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_valid(o_valid), .o_byte(o_byte), .i_ready(i_ready),
    .o_reg_en(o_reg_en), .o_reg_wr(o_reg_wr), .o_reg_addr(o_reg_addr),
    .o_reg_wdata(o_reg_wdata), .i_reg_rdata(i_reg_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Register-slave model and observers, all advanced once per cycle.
  logic [7:0] wr_q[$], rx_q[$], out_q[$];
  int   so_cnt, si_cnt, rdy_delay, si_polls, en_cnt, viol, done_cnt;
  int   stall_idx, stall_len, stall_cnt;
  bit   si_never, running, err_at_done, poke_start;
  logic [7:0] held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    so_cnt++;
    si_cnt++;
    if (running && !o_busy && !o_done) viol++;
    if (o_done) begin
      done_cnt++;
      err_at_done = o_err;
    end
    if (o_reg_en) begin
      en_cnt++;
      if (o_valid) viol++;
      if (o_reg_wr) begin
        if (o_reg_addr == 4'd1) begin
          wr_q.push_back(o_reg_wdata);
          so_cnt = 0;
        end else viol++;
      end else begin
        case (o_reg_addr)
          4'd0: i_reg_rdata = (so_cnt > rdy_delay) ? 8'h01 : 8'h00;
          4'd2: begin
            si_polls++;
            i_reg_rdata = (!si_never && si_cnt > rdy_delay) ? 8'h80 : 8'h00;
          end
          4'd3: begin
            i_reg_rdata = 8'($urandom);
            rx_q.push_back(i_reg_rdata);
            si_cnt = 0;
          end
          default: viol++;
        endcase
      end
    end
    if (o_valid && out_q.size() == stall_idx && stall_cnt < stall_len) begin
      if (stall_cnt == 0) held = o_byte;
      else if (o_byte !== held) viol++;
      stall_cnt++;
      i_ready = 1'b0;
    end else begin
      i_ready = 1'b1;
    end
    if (o_valid && i_ready) out_q.push_back(o_byte);
    if (running) i_start = poke_start && ($urandom_range(0, 7) == 0);
  endtask

  task automatic run(input logic [23:0] a, input int len, input int dly, input bit never,
                     input int sidx, input int slen, output int cycles);
    wr_q.delete(); rx_q.delete(); out_q.delete();
    so_cnt = 0; si_cnt = 0; rdy_delay = dly; si_never = never; si_polls = 0;
    en_cnt = 0; viol = 0; done_cnt = 0; err_at_done = 1'b0;
    stall_idx = sidx; stall_len = slen; stall_cnt = 0;
    i_faddr = a; i_len = 8'(len); i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_faddr = 24'($urandom);
    i_len   = 8'($urandom);
    running = 1'b1;
    cycles  = 1;
    while (done_cnt == 0 && cycles < 20000) begin
      tick();
      cycles++;
    end
    running = 1'b0;
    i_start = 1'b0;
    tick();
    check("done_seen", (done_cnt > 0), 1);
  endtask

  task automatic verify(input logic [23:0] a, input int len, input bit never);
    logic [7:0] exp_w[$];
    exp_w.push_back(OPC);
    exp_w.push_back(a[23:16]);
    exp_w.push_back(a[15:8]);
    exp_w.push_back(a[7:0]);
    for (int i = HDR; i < HDR + len; i++) exp_w.push_back(8'h00);
    if (HDR == 5) exp_w.insert(4, 8'h00);
    check("done_once", done_cnt, 1);
    check("protocol_viol", viol, 0);
    if (never) begin
      check("to_wr_count", wr_q.size(), 1);
      if (wr_q.size() > 0) check("to_wr_opcode", wr_q[0], OPC);
      check("to_si_dat_reads", rx_q.size(), 0);
      check("to_stream_count", out_q.size(), 0);
      check("to_si_polls", si_polls, LIM);
      check("to_err_at_done", err_at_done, 1);
    end else begin
      check("wr_count", wr_q.size(), HDR + len);
      for (int i = 0; i < wr_q.size() && i < HDR + len; i++)
        check($sformatf("wr_byte[%0d]", i), wr_q[i], exp_w[i]);
      check("si_dat_reads", rx_q.size(), HDR + len);
      check("stream_count", out_q.size(), len);
      for (int i = 0; i < out_q.size() && i + HDR < rx_q.size(); i++)
        check($sformatf("stream[%0d]", i), out_q[i], rx_q[i + HDR]);
      check("err_at_done", err_at_done, 0);
    end
  endtask

  initial begin
    int cyc, n;
    logic [23:0] a;
    i_rst_n = 1'b0; i_start = 1'b0; i_faddr = '0; i_len = '0;
    i_ready = 1'b1; i_reg_rdata = '0; running = 1'b0; poke_start = 1'b0;
    stall_len = 0; stall_idx = 0; stall_cnt = 0; si_never = 1'b0; rdy_delay = 0;
    #12;
    check("rst_outs", {o_busy, o_done, o_err, o_valid, o_reg_en, o_reg_wr,
                       o_reg_addr, o_reg_wdata, o_byte}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick(); tick();

    // Ready immediately.
    run(24'h012345, 3, 0, 1'b0, 0, 0, cyc);
    verify(24'h012345, 3, 1'b0);

    // Ready bits low ~10 cycles before each byte; stray starts while busy.
    poke_start = 1'b1;
    run(24'h012345, 3, 10, 1'b0, 0, 0, cyc);
    verify(24'h012345, 3, 1'b0);
    poke_start = 1'b0;

    // 20-cycle backpressure on the second payload byte.
    run(24'hABCDEF, 3, 0, 1'b0, 1, 20, cyc);
    verify(24'hABCDEF, 3, 1'b0);
    check("stall_cycles", stall_cnt, 20);

    // SI_RDY never asserts: timeout, error held, cleared by next start.
    a = 24'($urandom);
    run(a, 3, 0, 1'b1, 0, 0, cyc);
    verify(a, 3, 1'b1);
    check("err_held_idle", o_err, 1);
    a = 24'($urandom);
    run(a, 2, 1, 1'b0, 0, 0, cyc);
    verify(a, 2, 1'b0);
    check("err_cleared", o_err, 0);

    // Zero-length request.
    run(24'h55AA55, 0, 0, 1'b0, 0, 0, cyc);
    check("len0_done_latency", cyc, 1);
    check("len0_no_bus", en_cnt, 0);
    check("len0_done_once", done_cnt, 1);

    // Reset during byte 2 of a len=4 transfer.
    wr_q.delete(); rx_q.delete(); out_q.delete();
    done_cnt = 0; rdy_delay = 0; si_never = 1'b0; stall_len = 0; stall_cnt = 0;
    i_faddr = 24'h102030; i_len = 8'd4; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (wr_q.size() < 2 && n < 2000) begin
      tick();
      n++;
    end
    check("rst_mid_reached", wr_q.size(), 2);
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {o_busy, o_done, o_err, o_valid, o_reg_en, o_reg_wr,
                           o_reg_addr, o_reg_wdata, o_byte}, 0);
    tick(); tick();
    check("rst_mid_hold", {o_busy, o_done, o_reg_en}, 0);
    check("rst_mid_no_done", done_cnt, 0);
    i_rst_n = 1'b1;
    tick();
    a = 24'($urandom);
    run(a, 5, 2, 1'b0, 0, 0, cyc);
    verify(a, 5, 1'b0);

    // Randomised transfers.
    poke_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int len, dly, sidx, slen;
      a    = 24'($urandom);
      len  = $urandom_range(1, 12);
      dly  = $urandom_range(0, 6);
      sidx = $urandom_range(0, len - 1);
      slen = $urandom_range(0, 5);
      run(a, len, dly, 1'b0, sidx, slen, cyc);
      verify(a, len, 1'b0);
    end
    poke_start = 1'b0;

    // Full-scale length: index must not wrap.
    a = 24'($urandom);
    run(a, 255, 0, 1'b0, 0, 0, cyc);
    verify(a, 255, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
